eprisc_sysx_target: RTL and testbench

EPRISC_SYSX_TARGET -- requirements
Module: eprisc_sysx_target

---
 rtl/eprisc_sysx_pkg.sv | 20 ++
 rtl/eprisc_sysx_target_if.sv | 19 +
 rtl/eprisc_sysx_edge_sync.sv | 35 +++
 rtl/eprisc_sysx_target.sv | 227 ++++++++++++++++++++++
 tb/tb_eprisc_sysx_target.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/eprisc_sysx_pkg.sv
// eprisc sysX target: shared types and constants for the bus target and its bench.
`timescale 1ns/1ps
package eprisc_sysx_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    TURN = 3'd2,
    DATA = 3'd3,
    DONE = 3'd4
  } sysxState_e;

  // Bit of the command byte that selects write (1) or read (0); bits below it are the address.
  localparam int         CMD_WRITE_BIT  = 7;
  // Value the target leaves on the MISO lane whenever it is not returning read data.
  localparam logic [7:0] MISO_IDLE      = 8'hFF;
  // Writing this address acknowledges the pending interrupt when the IRQ feature is built in.
  localparam logic [6:0] IRQ_CLEAR_ADDR = 7'h7F;

endpackage

// File: rtl/eprisc_sysx_target_if.sv
// eprisc sysX target: byte-lane bus between a sysX master and one target slot.
`timescale 1ns/1ps
interface eprisc_sysx_target_if;
  logic       iBusClock;
  logic [1:0] iBusSelect;
  logic [7:0] iBusMOSI;
  logic [7:0] oBusMISO;
  logic       oBusInterrupt;

  modport master (
    output iBusClock, iBusSelect, iBusMOSI,
    input  oBusMISO, oBusInterrupt
  );

  modport slave (
    input  iBusClock, iBusSelect, iBusMOSI,
    output oBusMISO, oBusInterrupt
  );
endinterface

// File: rtl/eprisc_sysx_edge_sync.sv
// eprisc sysX target: multi-flop synchronizer with rise/fall detection on the
// synchronized copy. Each bit is synchronized independently.
`timescale 1ns/1ps
module eprisc_sysx_edge_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic [WIDTH-1:0] iAsync,
  output logic [WIDTH-1:0] oSync,
  output logic [WIDTH-1:0] oRise,
  output logic [WIDTH-1:0] oFall
);

  logic [WIDTH-1:0] syncChain [STAGES];
  logic [WIDTH-1:0] syncPrev;

  // Shift the asynchronous input through the chain and keep the last synchronized value.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      for (int i = 0; i < STAGES; i++) syncChain[i] <= '0;
      syncPrev <= '0;
    end else begin
      syncChain[0] <= iAsync;
      for (int i = 1; i < STAGES; i++) syncChain[i] <= syncChain[i-1];
      syncPrev <= syncChain[STAGES-1];
    end
  end

  assign oSync = syncChain[STAGES-1];
  assign oRise = oSync & ~syncPrev;
  assign oFall = ~oSync & syncPrev;

endmodule

// File: rtl/eprisc_sysx_target.sv
// eprisc sysX target: converts sysX byte-lane frames into one-cycle local
// register read/write strobes. Optional feature macro SYSX_TARGET_IRQ_EN adds a
// pending-interrupt latch that is cleared by writing address 7'h7F.
`timescale 1ns/1ps
module eprisc_sysx_target
  import eprisc_sysx_pkg::*;
#(
  parameter logic [1:0] SLOT        = 2'd1,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                        iClock,
  input  logic                        iReset,
  eprisc_sysx_target_if.slave         bus,
  output logic [6:0]                  oRegAddr,
  output logic [31:0]                 oRegWData,
  output logic                        oRegWrite,
  output logic                        oRegRead,
  input  logic [31:0]                 iRegRData,
  input  logic                        iIrqPulse
);

  // Cycles after reset before the synchronized select is trusted to arm a frame.
  localparam int SETTLE_MAX = SYNC_STAGES + 1;
  localparam int SETTLE_W   = $clog2(SETTLE_MAX + 1);

  logic       busRise;
  logic       busFall;
  logic       unusedBusClock;
  logic [1:0] selSync;
  logic [1:0] selRise;
  logic [1:0] selFall;

  logic [7:0] mosiChain [SYNC_STAGES];
  logic [7:0] mosi;

  sysxState_e          state, stateNext;
  logic                selActive, selActiveNext;
  logic                armed, armedNext;
  logic [SETTLE_W-1:0] settleCnt, settleCntNext;
  logic                isWrite, isWriteNext;
  logic [1:0]          byteCnt, byteCntNext;
  logic [6:0]          addrNext;
  logic [31:0]         wDataNext;
  logic [31:0]         rdShift, rdShiftNext;
  logic [7:0]          misoReg, misoNext;
  logic                wrPend, wrPendNext;
  logic                rdCap, rdCapNext;
  logic                writeNext, readNext;
  logic                selStable, selMatch, settled, irqClear;

  eprisc_sysx_edge_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) uClockSync (
    .iClock (iClock),
    .iReset (iReset),
    .iAsync (bus.iBusClock),
    .oSync  (unusedBusClock),
    .oRise  (busRise),
    .oFall  (busFall)
  );

  eprisc_sysx_edge_sync #(.WIDTH(2), .STAGES(SYNC_STAGES)) uSelectSync (
    .iClock (iClock),
    .iReset (iReset),
    .iAsync (bus.iBusSelect),
    .oSync  (selSync),
    .oRise  (selRise),
    .oFall  (selFall)
  );

  // MOSI is sampled only on synchronized rising edges, so matching the clock depth keeps them aligned.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      for (int i = 0; i < SYNC_STAGES; i++) mosiChain[i] <= '0;
    end else begin
      mosiChain[0] <= bus.iBusMOSI;
      for (int i = 1; i < SYNC_STAGES; i++) mosiChain[i] <= mosiChain[i-1];
    end
  end

  assign mosi = mosiChain[SYNC_STAGES-1];

  // Select bits are synchronized separately; only accept a code once no bit moved this cycle.
  assign selStable = ~|(selRise | selFall);
  assign selMatch  = (selSync == SLOT);
  assign settled   = (settleCnt == SETTLE_W'(SETTLE_MAX));

`ifdef SYSX_TARGET_IRQ_EN
  logic irqPend;
  assign irqClear = wrPend & selActive & (oRegAddr == IRQ_CLEAR_ADDR);

  // Pending interrupt latch; a new event in the same cycle as a clear keeps it set.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) irqPend <= 1'b0;
    else        irqPend <= iIrqPulse | (irqPend & ~irqClear);
  end

  assign bus.oBusInterrupt = irqPend;
`else
  logic unusedIrqPulse;
  assign unusedIrqPulse    = iIrqPulse;
  assign irqClear          = 1'b0;
  assign bus.oBusInterrupt = 1'b0;
`endif

  // Frame state and datapath registers.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state     <= IDLE;
      selActive <= 1'b0;
      armed     <= 1'b0;
      settleCnt <= '0;
      isWrite   <= 1'b0;
      byteCnt   <= '0;
      oRegAddr  <= '0;
      oRegWData <= '0;
      rdShift   <= '0;
      misoReg   <= MISO_IDLE;
      wrPend    <= 1'b0;
      rdCap     <= 1'b0;
      oRegWrite <= 1'b0;
      oRegRead  <= 1'b0;
    end else begin
      state     <= stateNext;
      selActive <= selActiveNext;
      armed     <= armedNext;
      settleCnt <= settleCntNext;
      isWrite   <= isWriteNext;
      byteCnt   <= byteCntNext;
      oRegAddr  <= addrNext;
      oRegWData <= wDataNext;
      rdShift   <= rdShiftNext;
      misoReg   <= misoNext;
      wrPend    <= wrPendNext;
      rdCap     <= rdCapNext;
      oRegWrite <= writeNext;
      oRegRead  <= readNext;
    end
  end

  // Selection tracking, frame sequencing and strobe generation.
  always_comb begin
    stateNext     = state;
    isWriteNext   = isWrite;
    byteCntNext   = byteCnt;
    addrNext      = oRegAddr;
    wDataNext     = oRegWData;
    rdShiftNext   = rdShift;
    misoNext      = misoReg;
    wrPendNext    = 1'b0;
    rdCapNext     = oRegRead;
    writeNext     = 1'b0;
    readNext      = 1'b0;
    settleCntNext = settled ? settleCnt : settleCnt + 1'b1;

    // After reset a frame needs the master to show a non-matching select first.
    armedNext     = armed | (settled & selStable & ~selMatch);
    selActiveNext = selActive;
    if (selStable) selActiveNext = selMatch & (selActive | armed);

    // Read data arrives the cycle after the read strobe.
    if (rdCap) rdShiftNext = iRegRData;

    // The write strobe is issued one cycle after the last byte, if still selected.
    if (wrPend && selActive && !irqClear) writeNext = 1'b1;

    if (!selActive) begin
      stateNext   = IDLE;
      byteCntNext = '0;
      misoNext    = MISO_IDLE;
    end else begin
      case (state)
        IDLE: begin
          stateNext   = CMD;
          byteCntNext = '0;
        end
        CMD: begin
          if (busRise) begin
            isWriteNext = mosi[CMD_WRITE_BIT];
            addrNext    = mosi[CMD_WRITE_BIT-1:0];
            byteCntNext = '0;
            if (mosi[CMD_WRITE_BIT]) begin
              stateNext = DATA;
            end else begin
              readNext  = 1'b1;
              stateNext = TURN;
            end
          end
        end
        TURN: begin
          if (busRise) stateNext = DATA;
        end
        DATA: begin
          if (isWrite) begin
            if (busRise) begin
              wDataNext   = {oRegWData[23:0], mosi};
              byteCntNext = byteCnt + 2'd1;
              if (byteCnt == 2'd3) begin
                wrPendNext = 1'b1;
                stateNext  = DONE;
              end
            end
          end else begin
            // Present the next byte on the falling edge so it is stable at the master's rising edge.
            if (busFall) misoNext = rdShift[31:24];
            if (busRise) begin
              rdShiftNext = {rdShift[23:0], 8'h00};
              byteCntNext = byteCnt + 2'd1;
              if (byteCnt == 2'd3) begin
                stateNext = DONE;
                misoNext  = MISO_IDLE;
              end
            end
          end
        end
        DONE: begin
          misoNext = MISO_IDLE;
        end
        default: begin
          stateNext = IDLE;
          misoNext  = MISO_IDLE;
        end
      endcase
    end
  end

  assign bus.oBusMISO = misoReg;

endmodule

// File: tb/tb_eprisc_sysx_target.sv
// Bench for eprisc_sysx_target: table of bus frames plus hand-written abort,
// reset and interrupt sequences; register strobes checked through a scoreboard.
`timescale 1ns/1ps
module tb_eprisc_sysx_target;
  import eprisc_sysx_pkg::*;

  localparam logic [1:0] SLOT = 2'd1;
`ifdef SYSX_TARGET_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic        iClock = 1'b0;
  logic        iReset;
  logic [6:0]  oRegAddr;
  logic [31:0] oRegWData;
  logic        oRegWrite;
  logic        oRegRead;
  logic [31:0] iRegRData;
  logic        iIrqPulse;

  eprisc_sysx_target_if bus();

  eprisc_sysx_target #(.SLOT(SLOT), .SYNC_STAGES(2)) dut (
    .iClock    (iClock),
    .iReset    (iReset),
    .bus       (bus.slave),
    .oRegAddr  (oRegAddr),
    .oRegWData (oRegWData),
    .oRegWrite (oRegWrite),
    .oRegRead  (oRegRead),
    .iRegRData (iRegRData),
    .iIrqPulse (iIrqPulse)
  );

  always #5 iClock = ~iClock;

  typedef struct {
    logic        isWr;
    logic [6:0]  addr;
    logic [31:0] data;
  } ev_t;

  typedef struct {
    logic [1:0]  sel;
    logic        isWr;
    logic [6:0]  addr;
    logic [31:0] data;
    logic        expectEv;
  } vec_t;

  ev_t         sbQ[$];
  vec_t        vecs[9];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] rdValue  = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Local register responder: read data valid the cycle after the read strobe.
  always @(negedge iClock) begin
    if (oRegRead) iRegRData = rdValue;
  end

  // Scoreboard: every strobe must match the next expected event.
  always @(negedge iClock) begin
    if (!iReset && (oRegWrite || oRegRead)) begin
      checks++;
      if (sbQ.size() == 0) begin
        failures++;
        $display("FAIL unexpectedStrobe got wr=%0b rd=%0b addr=%h data=%h want none",
                 oRegWrite, oRegRead, oRegAddr, oRegWData);
      end else begin
        ev_t e;
        e = sbQ.pop_front();
        if (oRegWrite !== e.isWr || oRegRead !== !e.isWr || oRegAddr !== e.addr ||
            (e.isWr && oRegWData !== e.data)) begin
          failures++;
          $display("FAIL strobe got wr=%0b rd=%0b addr=%h data=%h want wr=%0b addr=%h data=%h",
                   oRegWrite, oRegRead, oRegAddr, oRegWData, e.isWr, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick(input logic [7:0] mosiByte, output logic [7:0] misoByte);
    bus.iBusClock = 1'b0;
    bus.iBusMOSI  = mosiByte;
    #60;
    misoByte      = bus.oBusMISO;
    bus.iBusClock = 1'b1;
    #60;
  endtask

  task automatic runFrame(input string tag, input vec_t v);
    logic [7:0] m;
    logic [7:0] want;
    if (v.expectEv) sbQ.push_back('{isWr: v.isWr, addr: v.addr, data: v.data});
    rdValue         = v.data;
    bus.iBusSelect  = v.sel;
    #100;
    tick({v.isWr, v.addr}, m);
    check({tag, "_cmdMiso"}, {24'h0, m}, {24'h0, MISO_IDLE});
    if (v.isWr) begin
      for (int i = 0; i < 4; i++) begin
        tick(v.data[31-8*i -: 8], m);
        check($sformatf("%s_wrMiso%0d", tag, i), {24'h0, m}, {24'h0, MISO_IDLE});
      end
    end else begin
      tick(8'h00, m);
      check({tag, "_turnMiso"}, {24'h0, m}, {24'h0, MISO_IDLE});
      for (int i = 0; i < 4; i++) begin
        tick(8'h00, m);
        want = v.expectEv ? v.data[31-8*i -: 8] : MISO_IDLE;
        check($sformatf("%s_rdByte%0d", tag, i), {24'h0, m}, {24'h0, want});
      end
    end
    #100;
    check({tag, "_postMiso"}, {24'h0, bus.oBusMISO}, {24'h0, MISO_IDLE});
    bus.iBusSelect = 2'd0;
    #100;
    check({tag, "_sbEmpty"}, sbQ.size(), 0);
  endtask

  initial begin
    logic [7:0] m;
    int         drops;

    vecs[0] = '{sel: 2'd1, isWr: 1'b1, addr: 7'h05, data: 32'hDEADBEEF, expectEv: 1'b1};
    vecs[1] = '{sel: 2'd1, isWr: 1'b0, addr: 7'h12, data: 32'h01234567, expectEv: 1'b1};
    vecs[2] = '{sel: 2'd2, isWr: 1'b1, addr: 7'h05, data: 32'hCAFEF00D, expectEv: 1'b0};
    vecs[3] = '{sel: 2'd1, isWr: 1'b1, addr: 7'h33, data: 32'hA5A55A5A, expectEv: 1'b1};
    vecs[4] = '{sel: 2'd1, isWr: 1'b0, addr: 7'h7E, data: 32'h89ABCDEF, expectEv: 1'b1};
    vecs[5] = '{sel: 2'd0, isWr: 1'b0, addr: 7'h12, data: 32'h0F0F0F0F, expectEv: 1'b0};
    vecs[6] = '{sel: 2'd3, isWr: 1'b1, addr: 7'h12, data: 32'h12345678, expectEv: 1'b0};
    vecs[7] = '{sel: 2'd1, isWr: 1'b1, addr: 7'h7F, data: 32'h00000000, expectEv: !IRQ_EN};
    vecs[8] = '{sel: 2'd1, isWr: 1'b0, addr: 7'h7F, data: 32'hC3C3C3C3, expectEv: 1'b1};

    iReset         = 1'b1;
    iIrqPulse      = 1'b0;
    iRegRData      = 32'h0;
    bus.iBusClock  = 1'b1;
    bus.iBusSelect = 2'd0;
    bus.iBusMOSI   = 8'h00;
    #23;
    check("rst_miso",  {24'h0, bus.oBusMISO}, {24'h0, MISO_IDLE});
    check("rst_irq",   {31'h0, bus.oBusInterrupt}, 32'h0);
    check("rst_addr",  {25'h0, oRegAddr}, 32'h0);
    check("rst_wdata", oRegWData, 32'h0);
    check("rst_wr",    {31'h0, oRegWrite}, 32'h0);
    check("rst_rd",    {31'h0, oRegRead}, 32'h0);
    iReset = 1'b0;
    #100;

    // Interrupt event before the table; the 7F write in the table clears it.
    @(negedge iClock) iIrqPulse = 1'b1;
    @(negedge iClock) iIrqPulse = 1'b0;
    @(negedge iClock);
    check("irqSet", {31'h0, bus.oBusInterrupt}, {31'h0, IRQ_EN});

    for (int i = 0; i < 9; i++) runFrame($sformatf("v%0d", i), vecs[i]);
    check("irqCleared", {31'h0, bus.oBusInterrupt}, 32'h0);

    // Deselect after the second data byte of a write: no strobe, next frame still decodes.
    bus.iBusSelect = SLOT;
    #100;
    tick(8'h85, m);
    tick(8'hDE, m);
    tick(8'hAD, m);
    bus.iBusSelect = 2'd0;
    #100;
    check("abort_sbEmpty", sbQ.size(), 0);
    runFrame("afterAbort", '{sel: 2'd1, isWr: 1'b1, addr: 7'h05, data: 32'h11223344, expectEv: 1'b1});

    // Interrupt event held across the clearing write: set must win.
    @(negedge iClock) iIrqPulse = 1'b1;
    @(negedge iClock) iIrqPulse = 1'b0;
    if (!IRQ_EN) sbQ.push_back('{isWr: 1'b1, addr: 7'h7F, data: 32'h0000AA55});
    bus.iBusSelect = SLOT;
    #100;
    tick(8'hFF, m);
    tick(8'h00, m);
    tick(8'h00, m);
    tick(8'hAA, m);
    @(negedge iClock) iIrqPulse = 1'b1;
    drops = 0;
    fork
      begin
        tick(8'h55, m);
        #100;
        @(negedge iClock) iIrqPulse = 1'b0;
      end
      begin
        repeat (20) @(negedge iClock) if (bus.oBusInterrupt !== IRQ_EN) drops++;
      end
    join
    check("irqCoincidentDrops", drops, 0);
    #30;
    check("irqHold", {31'h0, bus.oBusInterrupt}, {31'h0, IRQ_EN});
    bus.iBusSelect = 2'd0;
    #100;
    check("irqFrame_sbEmpty", sbQ.size(), 0);

    // Reset in the middle of a read data phase.
    rdValue = 32'h89ABCDEF;
    sbQ.push_back('{isWr: 1'b0, addr: 7'h12, data: 32'h0});
    bus.iBusSelect = SLOT;
    #100;
    tick(8'h12, m);
    tick(8'h00, m);
    tick(8'h00, m);
    check("midRead_byte0", {24'h0, m}, 32'h89);
    #23;
    iReset = 1'b1;
    #1;
    check("midRst_miso",  {24'h0, bus.oBusMISO}, {24'h0, MISO_IDLE});
    check("midRst_irq",   {31'h0, bus.oBusInterrupt}, 32'h0);
    check("midRst_addr",  {25'h0, oRegAddr}, 32'h0);
    check("midRst_wdata", oRegWData, 32'h0);
    check("midRst_wr",    {31'h0, oRegWrite}, 32'h0);
    check("midRst_rd",    {31'h0, oRegRead}, 32'h0);
    #30;
    iReset = 1'b0;
    #100;
    // Select never dropped, so this frame must be ignored.
    tick(8'h85, m);
    for (int i = 0; i < 4; i++) tick(8'h5A, m);
    #100;
    check("noReselect_miso", {24'h0, bus.oBusMISO}, {24'h0, MISO_IDLE});
    check("noReselect_sbEmpty", sbQ.size(), 0);
    bus.iBusSelect = 2'd0;
    #100;
    runFrame("recover", '{sel: 2'd1, isWr: 1'b0, addr: 7'h12, data: 32'h89ABCDEF, expectEv: 1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
